seg7_multi_display: RTL and testbench
=====================================

Name: seg7_multi_display

Overview:
- Parametrised successor to the fixed two-digit Tens/Ones seven-segment outputs of the microprocessor top.
- Converts a DATA_W-bit unsigned value to DIGITS seven-segment digits in one of two modes:
  - decimal, via a sequential double-dabble converter;
  - hex, via direct nibble slicing.
- Uses a load/busy/done handshake, and raises an overflow indication when the value does not fit.
- Sits between the datapath (register, address and instruction values) and the board's display pins.

Parameters:
- DATA_W, 8, width of the input value (1..32).
- DIGITS, 3, number of displayed digits (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- value  in  DATA_W  unsigned value to display.
- hex_mode  in  1  1 = hex digits, 0 = decimal digits; sampled with load.
- load  in  1  request conversion of value; accepted only when ready=1.
- ready  out  1  high in IDLE; equals ~busy.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when seg/overflow update.
- overflow  out  1  last displayed value did not fit in DIGITS digits.
- seg  out  7*DIGITS  digit i at seg[7*i+6:7*i]; digit 0 is least significant; bit6=a … bit0=g; active-high.

Behaviour:
- Reset, including mid-conversion:
  - seg=0 (all segments off), done=0, busy=0, overflow=0, FSM to IDLE.
  - Any conversion in progress is aborted with no seg update.
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - load=1 at edge k latches value and hex_mode.
  - Decimal: go to CONV with shift count 0 and BCD register cleared.
  - Hex: go directly to UPDATE.
- CONV:
  - Each cycle, every BCD digit ≥5 gets +3, then {bcd, shift} shifts left by one, MSB first.
  - The BCD register is 4*DIGITS bits.
  - Any 1 shifted out of the BCD MSB sets an internal overflow flag.
  - After exactly DATA_W shifts, go to UPDATE.
- UPDATE:
  - seg, overflow and done=1 are registered this cycle; return to IDLE.
- Latency, with load sampled at edge k:
  - decimal: seg valid after edge k+DATA_W+1;
  - hex: seg valid after edge k+1.
  - done is high for exactly the cycle following that edge.
- busy=1 from the edge after load acceptance until the edge at which done asserts; ready=~busy.
- load while busy is ignored; no queueing, and value/hex_mode changes during CONV have no effect.
- load in the same cycle done is high is accepted, because the FSM is already in IDLE.
- Hex mode:
  - digit i = value[4i+3:4i], zero-extended beyond DATA_W.
  - Overflow if any value bit at index ≥ 4*DIGITS is 1.
- Overflow display: every digit = dash (7'b0000001) and overflow=1. overflow clears on the next non-overflowing update.
- Glyphs:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- seg holds its value between updates.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant non-zero digit are blanked (7'b0000000). Digit 0 always shows, so value 0 shows a single "0". Overflow dashes are never blanked.
- Undefined: all digits are always shown, leading zeros included.
- Latency is the same either way.

Decomposition:
- Package seg7_pkg:
  - glyph constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK;
  - FSM state typedef/localparams (IDLE, CONV, UPDATE).
- Sub-module seg7_encode: combinational 4-bit nibble → 7-bit glyph. Instantiated DIGITS times.
- The FSM and double-dabble stay in seg7_multi_display.

Test Plan:
- DATA_W=8, DIGITS=3, decimal 255 at edge k:
  - done at cycle k+10;
  - seg = {1101101, 1011011, 1011011} ("255"), overflow=0;
  - busy high for cycles k+1..k+9.
- Hex mode, value 0xA7, DIGITS=3:
  - done one cycle after load;
  - seg = {1111110, 1110111, 1110000} ("0A7").
- DIGITS=2, decimal 200:
  - all digits 0000001, overflow=1;
  - a following load of 42 shows "42" with overflow=0.
- Load 99 during CONV of 123:
  - second load ignored; display "123";
  - a new load accepted on the done cycle converts correctly.
- Reset at the fourth CONV cycle:
  - seg=0, busy=0, done never pulses;
  - the next load of 5 shows "005".
- With SEG7_LEADING_ZERO_BLANK_EN, decimal 7: seg = {0000000, 0000000, 1110000}. Value 0 shows only digit 0 = 1111110.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants and FSM state type for the multi-digit seven-segment display.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-glyph decoder (bit6=a ... bit0=g, active-high).
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    // NOTE: default first so every path assigns glyph and no latch is inferred.
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_multi_display.sv
// DATA_W-bit value to DIGITS seven-segment digits, decimal (double dabble) or hex.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero digit.
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  hex_mode,
  input  logic                  load,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t             state;
  logic [DATA_W-1:0]  shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic               carry_out;
  logic               ovf_flag;
  logic               hex_q;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        value_ext;
  logic               hex_ovf;
  logic [BCD_W-1:0]   nib;
  logic               ovf_next;
  logic [6:0]         glyph [DIGITS];
  logic [7*DIGITS-1:0] seg_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next value bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_shifted = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
    carry_out   = bcd_adj[BCD_W-1];
  end

  // In hex mode shift_q still holds the latched value, untouched by CONV.
  assign value_ext = 64'(shift_q);
  assign hex_ovf   = |(value_ext >> BCD_W);
  assign nib       = hex_q ? value_ext[BCD_W-1:0] : bcd_q;
  assign ovf_next  = hex_q ? hex_ovf : ovf_flag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .nibble (nib[4*g +: 4]),
      .glyph  (glyph[g])
    );
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  always_comb begin
    seg_next = '0;
    seen_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_next)                                          seg_next[7*i +: 7] = SEG_DASH;
      else if (i != 0 && !seen_nz && nib[4*i +: 4] == 4'd0)  seg_next[7*i +: 7] = SEG_BLANK;
      else                                                   seg_next[7*i +: 7] = glyph[i];
      seen_nz = seen_nz | (nib[4*i +: 4] != 4'd0);
    end
  end
`else
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = ovf_next ? SEG_DASH : glyph[i];
    end
  end
`endif

  assign ready = ~busy;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg      <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      hex_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_q  <= value;
            hex_q    <= hex_mode;
            bcd_q    <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= hex_mode ? UPDATE : CONV;
          end
        end
        CONV: begin
          bcd_q    <= bcd_shifted;
          shift_q  <= shift_q << 1;
          ovf_flag <= ovf_flag | carry_out;
          if (cnt == CNT_W'(DATA_W - 1)) state <= UPDATE;
          else                           cnt   <= cnt + CNT_W'(1);
        end
        UPDATE: begin
          seg      <= seg_next;
          overflow <= ovf_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench for seg7_multi_display: a 3-digit and a 2-digit instance, both 8-bit.
`timescale 1ns/1ps
module tb_seg7_multi_display;

  localparam logic [6:0] G0 = 7'b1111110, G2 = 7'b1101101, G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011, G5 = 7'b1011011, G7 = 7'b1110000;
  localparam logic [6:0] G1 = 7'b0110000, G9 = 7'b1111011, GA = 7'b1110111;
  localparam logic [6:0] GC = 7'b1001110, DASH = 7'b0000001;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = G0;
`endif

  typedef struct {
    logic [20:0] seg;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic [7:0]  value;
  logic        hex_mode;
  logic        load1, load2;
  logic        ready1, busy1, done1, ovf1;
  logic        ready2, busy2, done2, ovf2;
  logic [20:0] seg1;
  logic [13:0] seg2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   done_cnt1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_multi_display #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk), .Reset(Reset), .value(value), .hex_mode(hex_mode), .load(load1),
    .ready(ready1), .busy(busy1), .done(done1), .overflow(ovf1), .seg(seg1)
  );

  seg7_multi_display #(.DATA_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .Reset(Reset), .value(value), .hex_mode(hex_mode), .load(load2),
    .ready(ready2), .busy(busy2), .done(done2), .overflow(ovf2), .seg(seg2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      exp_t e;
      done_cnt1++;
      if (q1.size() == 0) check("spurious_done1", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        check("seg1", 32'(seg1), 32'(e.seg));
        check("ovf1", 32'(ovf1), 32'(e.ovf));
        check("latency1", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      exp_t e;
      if (q2.size() == 0) check("spurious_done2", 32'(done2), 32'd0);
      else begin
        e = q2.pop_front();
        check("seg2", 32'(seg2), 32'(e.seg));
        check("ovf2", 32'(ovf2), 32'(e.ovf));
        check("latency2", cyc, e.cyc);
      end
    end
  end

  task automatic issue1(input logic [7:0] v, input logic hx, input logic [20:0] es, input logic eo);
    @(posedge clk); #1;
    value = v; hex_mode = hx; load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    q1.push_back('{seg: es, ovf: eo, cyc: cyc + (hx ? 1 : 9)});
  endtask

  task automatic issue2(input logic [7:0] v, input logic hx, input logic [13:0] es, input logic eo);
    @(posedge clk); #1;
    value = v; hex_mode = hx; load2 = 1'b1;
    @(posedge clk); #1;
    load2 = 1'b0;
    q2.push_back('{seg: 21'(es), ovf: eo, cyc: cyc + (hx ? 1 : 9)});
  endtask

  task automatic wait_idle1();
    int n = 0;
    while ((busy1 || q1.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("idle1_in_time", 32'(busy1 || q1.size() != 0), 32'd0);
  endtask

  task automatic wait_idle2();
    int n = 0;
    while ((busy2 || q2.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("idle2_in_time", 32'(busy2 || q2.size() != 0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    Reset = 1'b1; value = '0; hex_mode = 1'b0; load1 = 1'b0; load2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    Reset = 1'b0;

    // Decimal 255: busy for exactly nine cycles, then done.
    issue1(8'd255, 1'b0, {G2, G5, G5}, 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("busy_conv", 32'(busy1), 32'd1);
      check("ready_conv", 32'(ready1), 32'd0);
      @(posedge clk); #1;
    end
    check("busy_after", 32'(busy1), 32'd0);
    check("ready_after", 32'(ready1), 32'd1);
    wait_idle1();

    issue1(8'hA7, 1'b1, {LZ, GA, G7}, 1'b0);
    wait_idle1();
    issue1(8'h3C, 1'b1, {LZ, G3, GC}, 1'b0);
    wait_idle1();

    // 123 with a 99 load during CONV, then 42 loaded in the done cycle.
    issue1(8'd123, 1'b0, {G1, G2, G3}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    value = 8'd99; load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("done_123_seen", 32'(done1), 32'd1);
    value = 8'd42; hex_mode = 1'b0; load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    q1.push_back('{seg: {LZ, G4, G2}, ovf: 1'b0, cyc: cyc + 9});
    wait_idle1();

    // Reset in the fourth CONV cycle aborts with no update.
    @(posedge clk); #1;
    value = 8'd77; hex_mode = 1'b0; load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    check("abort_seg", 32'(seg1), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_ready", 32'(ready1), 32'd1);
    d = done_cnt1;
    repeat (12) @(posedge clk);
    check("abort_no_done", done_cnt1, d);

    issue1(8'd5, 1'b0, {LZ, LZ, G5}, 1'b0);
    wait_idle1();
    issue1(8'd7, 1'b0, {LZ, LZ, G7}, 1'b0);
    wait_idle1();
    issue1(8'd0, 1'b0, {LZ, LZ, G0}, 1'b0);
    wait_idle1();

    // Two-digit instance: overflow boundaries and recovery.
    issue2(8'd200, 1'b0, {DASH, DASH}, 1'b1);
    wait_idle2();
    issue2(8'd42, 1'b0, {G4, G2}, 1'b0);
    wait_idle2();
    issue2(8'd99, 1'b0, {G9, G9}, 1'b0);
    wait_idle2();
    issue2(8'd100, 1'b0, {DASH, DASH}, 1'b1);
    wait_idle2();
    issue2(8'hA7, 1'b1, {GA, G7}, 1'b0);
    wait_idle2();

    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
